multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles mem_req may wait for mem_ready before bus error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  7  instruction register bits [6:0].
REQ-005 SHALL have port branch_taken  input  1  ALU branch compare result, valid in EXECUTE.
REQ-006 SHALL have port mem_ready  input  1  memory accepts/returns data this cycle.
REQ-007 SHALL have ports mem_req, mem_we, mem_addr_sel (0=PC, 1=ALU result)  output  1 each.
REQ-008 SHALL have ports ir_we, pc_we, rf_we  output  1 each  register write strobes.
REQ-009 SHALL have ports pc_sel (0=PC+4, 1=branch/jump target) and alu_b_sel (0=rs2, 1=immediate)  output  1 each.
REQ-010 SHALL have port wb_sel  output  2  writeback source: 0=ALU, 1=memory data, 2=PC+4.
REQ-011 SHALL have ports retire, illegal, bus_err  output  1 each; state  output  3; instr_count  output  32.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-013 FETCH: mem_req=1, mem_addr_sel=0; on mem_ready=1, ir_we=1 that cycle, next state DECODE; otherwise stay.
REQ-014 DECODE: opcode 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL) go to EXECUTE; 0000000 (NOP) retires in DECODE and goes to FETCH; any other opcode goes to TRAP with illegal=1.
REQ-015 EXECUTE: alu_b_sel=1 for I-ALU/LOAD/STORE, else 0; R/I-ALU/JAL go to WRITEBACK; LOAD/STORE go to MEM; BRANCH retires here with pc_sel=branch_taken, then FETCH.
REQ-016 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; on mem_ready, LOAD goes to WRITEBACK, STORE retires and goes to FETCH; otherwise stay.
REQ-017 WRITEBACK: rf_we=1, wb_sel=0 (R/I-ALU), 1 (LOAD), 2 (JAL); pc_sel=1 for JAL else 0; retires; next FETCH.
REQ-018 Retire cycle SHALL assert pc_we=1 and retire=1 for exactly one cycle; pc_we SHALL be 0 in all other cycles.
REQ-019 Zero-wait latency (cycles FETCH-to-retire inclusive) SHALL be: NOP 2, BRANCH 3, R/I-ALU/JAL/STORE 4, LOAD 5; each mem_ready=0 cycle adds one.
REQ-020 Write strobes and mem_req SHALL be 0 in every state/condition not listed above; outputs are combinational from state, opcode, branch_taken, mem_ready.
REQ-021 Opcode SHALL be latched in DECODE and held until retire; opcode input changes after DECODE SHALL have no effect.
REQ-022 Wait counter SHALL count consecutive mem_req=1 cycles with mem_ready=0; when it reaches TIMEOUT, next state TRAP with bus_err=1; counter clears on mem_ready or state change.
REQ-023 mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL complete the access; no bus error.
REQ-024 TRAP SHALL be absorbing: all strobes 0, illegal/bus_err held, exit only by reset.
REQ-025 instr_count SHALL increment by 1 on each retire, wrapping 0xFFFFFFFF to 0.
REQ-026 state output SHALL encode FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.

Reset
REQ-027 reset=1 at any edge SHALL force state FETCH, clear wait counter, illegal, bus_err, latched opcode and instr_count to 0, overriding any in-progress access.
REQ-028 While reset=1 all outputs except state SHALL be 0; the first mem_req SHALL appear in the cycle after reset deasserts.

Structure
REQ-029 Opcode values, state encodings, and wb_sel/pc_sel encodings SHALL live in a shared header used by this block, the decoder and the bench.
REQ-030 The wait counter SHALL be a sub-module, mem_wait_timer (inputs clk, reset, busy, ready; output expired).

Verification
REQ-031 Zero-wait ADD (opcode 0110011) -> states 0,1,2,4; rf_we and retire in cycle 4; instr_count=1.
REQ-032 LOAD with mem_ready low 2 cycles in MEM -> retire on cycle 7, wb_sel=1 with rf_we=1.
REQ-033 BRANCH with branch_taken=1 then 0 -> pc_sel=1 then 0, both retire at cycle 3.
REQ-034 Opcode 1111111 -> TRAP in cycle after DECODE, illegal=1 sticky, no further mem_req until reset.
REQ-035 mem_ready held low in FETCH with TIMEOUT=15 -> TRAP with bus_err=1 after 15 waiting cycles; ready on the 15th cycle -> normal DECODE.
REQ-036 reset pulsed during a MEM stall -> FETCH next cycle, mem_we=0, instr_count=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller, its timer and its testbench.
// Contents: state encoding, opcode values, writeback/PC/address/ALU mux encodings,
// the opcode classes and the opcode-to-class decoder function.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic PC_SEL_PC4    = 1'b0;
  localparam logic PC_SEL_TARGET = 1'b1;
  localparam logic ADDR_SEL_PC   = 1'b0;
  localparam logic ADDR_SEL_ALU  = 1'b1;
  localparam logic ALUB_RS2      = 1'b0;
  localparam logic ALUB_IMM      = 1'b1;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_NOP,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e decode_op(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_NOP:    cls = CLS_NOP;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath/memory environment.
// master: controller side (drives strobes/selects/status, receives opcode,
//         branch_taken, mem_ready).
// slave:  environment side (the mirror image).
interface multicycle_controller_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        pc_sel;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;
  logic        retire;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, pc_sel,
           alu_b_sel, wb_sel, retire, illegal, bus_err, state, instr_count
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, pc_sel,
           alu_b_sel, wb_sel, retire, illegal, bus_err, state, instr_count
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles in which a memory request is pending (busy=1) but
// not answered (ready=0). expired is combinational: it flags the cycle whose
// wait would bring the count to TIMEOUT, so the controller can leave for TRAP
// on the following edge. A ready in that same cycle suppresses expired.
// Ports: clk, reset (sync, active-high), busy, ready -> expired.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ready,
  output logic expired
);
  import multicycle_controller_pkg::*;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    expired = busy && !ready && (cnt_q == LAST);
    if (!busy || ready || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// [WRITEBACK], with a sticky TRAP state for illegal opcodes and memory timeouts.
// Ports: clk, reset (sync, active-high), bus (master modport of
// multicycle_controller_if carrying opcode/branch_taken/mem_ready in and all
// strobes, selects, status, state and instr_count out).
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_controller_if.master    bus
);

  state_e      state_q, state_d;
  logic [6:0]  opcode_q;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] count_q;

  logic        mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, rf_we_c;
  logic        pc_sel_c, alu_b_c, retire_c;
  wb_sel_e     wb_sel_c;
  logic        expired;
  op_class_e   cls_in, cls_q;

  assign cls_in = decode_op(bus.opcode);
  assign cls_q  = decode_op(opcode_q);

  // mem_req is low in every non-memory state and the only exits from FETCH/MEM
  // are on ready (clears) or to TRAP (busy drops), so the counter always
  // restarts from zero on a state change.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .busy    (mem_req_c),
    .ready   (bus.mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = ADDR_SEL_PC;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    pc_sel_c   = PC_SEL_PC4;
    alu_b_c    = ALUB_RS2;
    wb_sel_c   = WB_ALU;
    retire_c   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_DECODE: begin
        case (cls_in)
          CLS_NOP: begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end
          default: state_d = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_R, CLS_JAL: state_d = ST_WRITEBACK;
          CLS_IALU: begin
            alu_b_c = ALUB_IMM;
            state_d = ST_WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_c = ALUB_IMM;
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            pc_sel_c = bus.branch_taken;
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = ADDR_SEL_ALU;
        mem_we_c   = (cls_q == CLS_STORE);
        if (bus.mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_WRITEBACK: begin
        rf_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
        case (cls_q)
          CLS_LOAD: wb_sel_c = WB_MEM;
          CLS_JAL: begin
            wb_sel_c = WB_PC4;
            pc_sel_c = PC_SEL_TARGET;
          end
          default: wb_sel_c = WB_ALU;
        endcase
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    pc_we_c = retire_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= bus.opcode;
      end
      if (retire_c) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Outputs are forced low while reset is held, whatever state is still registered.
  assign bus.mem_req      = mem_req_c  & ~reset;
  assign bus.mem_we       = mem_we_c   & ~reset;
  assign bus.mem_addr_sel = addr_sel_c & ~reset;
  assign bus.ir_we        = ir_we_c    & ~reset;
  assign bus.pc_we        = pc_we_c    & ~reset;
  assign bus.rf_we        = rf_we_c    & ~reset;
  assign bus.pc_sel       = pc_sel_c   & ~reset;
  assign bus.alu_b_sel    = alu_b_c    & ~reset;
  assign bus.wb_sel       = reset ? 2'b00 : wb_sel_c;
  assign bus.retire       = retire_c   & ~reset;
  assign bus.illegal      = illegal_q  & ~reset;
  assign bus.bus_err      = bus_err_q  & ~reset;
  assign bus.state        = state_q;
  assign bus.instr_count  = reset ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       bt;
    int         fw;   // mem_ready=0 cycles in FETCH
    int         mw;   // mem_ready=0 cycles in MEM
    int         lat;  // hand-computed FETCH-to-retire cycles
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, pc_sel, alu_b, wb_sel[1:0], retire}
  function automatic logic [10:0] strobes();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
            bus.rf_we, bus.pc_sel, bus.alu_b_sel, bus.wb_sel, bus.retire};
  endfunction

  function automatic logic [10:0] mk(input logic mreq, input logic mwe, input logic asel,
                                     input logic irwe, input logic pcwe, input logic rfwe,
                                     input logic pcs, input logic alub,
                                     input logic [1:0] wbs, input logic ret);
    return {mreq, mwe, asel, irwe, pcwe, rfwe, pcs, alub, wbs, ret};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("rst_outputs", {21'd0, strobes()}, 32'd0);
    check("rst_flags", {30'd0, bus.illegal, bus.bus_err}, 32'd0);
    check("rst_count", bus.instr_count, 32'd0);
    tick();
    reset = 1'b0;
    exp_count = 0;
  endtask

  // Runs one instruction from the FETCH cycle; expected state/strobes come
  // from the stage schedule implied by fw/mw and the instruction kind.
  task automatic run_vec(input vec_t v);
    logic       is_load, is_store, is_mem, is_nop, is_br, is_jal, is_imm, rdy;
    int         d, e, mem_last, last, seen;
    logic [2:0] es;
    logic [10:0] xs;
    logic [1:0] wbv;
    is_load  = (v.op == OP_LOAD);
    is_store = (v.op == OP_STORE);
    is_mem   = is_load || is_store;
    is_nop   = (v.op == OP_NOP);
    is_br    = (v.op == OP_BRANCH);
    is_jal   = (v.op == OP_JAL);
    is_imm   = (v.op == OP_IALU) || is_mem;
    wbv      = is_load ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
    d        = v.fw + 2;
    e        = d + 1;
    mem_last = e + v.mw + 1;
    if (is_nop)        last = d;
    else if (is_br)    last = e;
    else if (is_store) last = mem_last;
    else if (is_load)  last = mem_last + 1;
    else               last = e + 1;
    seen = 0;
    for (int c = 1; c <= last; c++) begin
      rdy = (c == v.fw + 1) || (is_mem && c == mem_last);
      bus.mem_ready = rdy;
      bus.opcode = (c == d) ? v.op : 7'h7F;
      bus.branch_taken = v.bt;
      if (c <= v.fw + 1) begin
        es = ST_FETCH;
        xs = mk(1, 0, 0, rdy, 0, 0, 0, 0, 2'd0, 0);
      end else if (c == d) begin
        es = ST_DECODE;
        xs = is_nop ? mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1) : '0;
      end else if (c == e) begin
        es = ST_EXECUTE;
        xs = is_br ? mk(0, 0, 0, 0, 1, 0, v.bt, 0, 2'd0, 1)
                   : mk(0, 0, 0, 0, 0, 0, 0, is_imm, 2'd0, 0);
      end else if (is_mem && c <= mem_last) begin
        es = ST_MEM;
        xs = mk(1, is_store, 1, 0, rdy & is_store, 0, 0, 0, 2'd0, rdy & is_store);
      end else begin
        es = ST_WRITEBACK;
        xs = mk(0, 0, 0, 0, 1, 1, is_jal, 0, wbv, 1);
      end
      @(negedge clk);
      check($sformatf("%s c%0d state", v.name, c), {29'd0, bus.state}, {29'd0, es});
      check($sformatf("%s c%0d strobes", v.name, c), {21'd0, strobes()}, {21'd0, xs});
      if (bus.retire && seen == 0) seen = c;
      tick();
    end
    check($sformatf("%s latency", v.name), seen, v.lat);
    exp_count++;
    check($sformatf("%s instr_count", v.name), bus.instr_count, exp_count);
  endtask

  initial begin
    vecs[0] = '{"add",      OP_R,      1'b0, 0, 0, 4};
    vecs[1] = '{"addi_fw2", OP_IALU,   1'b0, 2, 0, 6};
    vecs[2] = '{"load_mw2", OP_LOAD,   1'b0, 0, 2, 7};
    vecs[3] = '{"store_fw1",OP_STORE,  1'b0, 1, 0, 5};
    vecs[4] = '{"beq_t",    OP_BRANCH, 1'b1, 0, 0, 3};
    vecs[5] = '{"beq_nt",   OP_BRANCH, 1'b0, 0, 0, 3};
    vecs[6] = '{"jal",      OP_JAL,    1'b0, 0, 0, 4};
    vecs[7] = '{"nop",      OP_NOP,    1'b1, 0, 0, 2};
    vecs[8] = '{"load",     OP_LOAD,   1'b0, 0, 0, 5};
    vecs[9] = '{"store_mw3",OP_STORE,  1'b0, 0, 3, 7};

    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    apply_reset();

    // First cycle after reset: FETCH with mem_req already up.
    @(negedge clk);
    check("post_rst_state", {29'd0, bus.state}, 32'd0);
    check("post_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #1;
    @(posedge clk); // realign: this edge stays in FETCH (mem_ready=0)
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed during a STORE stall in MEM.
    bus.mem_ready = 1'b1; bus.opcode = 7'h7F; tick();
    bus.mem_ready = 1'b0; bus.opcode = OP_STORE; tick();
    bus.opcode = 7'h7F; tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_state", {29'd0, bus.state}, {29'd0, ST_MEM});
      check("stall_mem_we", {31'd0, bus.mem_we}, 32'd1);
      tick();
    end
    check("stall_count", bus.instr_count, exp_count);
    reset = 1'b1;
    @(negedge clk);
    check("stall_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("stall_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("after_stall_state", {29'd0, bus.state}, {29'd0, ST_FETCH});
    check("after_stall_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("after_stall_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("after_stall_count", bus.instr_count, 32'd0);

    // Illegal opcode -> sticky TRAP.
    apply_reset();
    bus.mem_ready = 1'b1; tick();
    bus.mem_ready = 1'b0; bus.opcode = 7'h7F;
    @(negedge clk);
    check("ill_decode_state", {29'd0, bus.state}, {29'd0, ST_DECODE});
    check("ill_decode_strobes", {21'd0, strobes()}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'b1; bus.opcode = OP_R;
      @(negedge clk);
      check("ill_trap_state", {29'd0, bus.state}, {29'd0, ST_TRAP});
      check("ill_sticky", {31'd0, bus.illegal}, 32'd1);
      check("ill_trap_strobes", {21'd0, strobes()}, 32'd0);
      tick();
    end
    apply_reset();
    @(negedge clk);
    check("ill_cleared", {31'd0, bus.illegal}, 32'd0);
    check("ill_cleared_state", {29'd0, bus.state}, {29'd0, ST_FETCH});

    // FETCH timeout: mem_ready low for TO cycles -> TRAP with bus_err.
    apply_reset();
    for (int c = 1; c <= TO; c++) begin
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check($sformatf("to_wait c%0d", c), {29'd0, bus.state}, {29'd0, ST_FETCH});
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("to_trap_state", {29'd0, bus.state}, {29'd0, ST_TRAP});
      check("to_bus_err", {31'd0, bus.bus_err}, 32'd1);
      check("to_trap_strobes", {21'd0, strobes()}, 32'd0);
      tick();
    end

    // Ready on the last allowed cycle completes the fetch normally.
    apply_reset();
    for (int c = 1; c < TO; c++) begin
      bus.mem_ready = 1'b0;
      tick();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("edge_ready_strobes", {21'd0, strobes()}, {21'd0, mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0)});
    tick();
    bus.mem_ready = 1'b0; bus.opcode = OP_NOP;
    @(negedge clk);
    check("edge_decode_state", {29'd0, bus.state}, {29'd0, ST_DECODE});
    check("edge_no_bus_err", {31'd0, bus.bus_err}, 32'd0);
    check("edge_nop_retire", {31'd0, bus.retire}, 32'd1);
    tick();
    check("edge_count", bus.instr_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
